// File: rtl/exe_muldiv_unit.sv
// Multi-cycle unsigned multiply / divide / remainder engine for the EXE stage.
// Stalls the front of the pipe while busy and emits a one-cycle result pulse.
module exe_muldiv_unit #(
    parameter int WORD_LEN    = 32,
    parameter int EXE_CMD_LEN = 4,
    parameter logic [EXE_CMD_LEN-1:0] CMD_MUL = 'hA,
    parameter logic [EXE_CMD_LEN-1:0] CMD_DIV = 'hB,
    parameter logic [EXE_CMD_LEN-1:0] CMD_REM = 'hC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [EXE_CMD_LEN-1:0] EXE_CMD,
    input  logic [WORD_LEN-1:0]    val1,
    input  logic [WORD_LEN-1:0]    val2,
    output logic                   stall,
    output logic                   busy,
    output logic                   done,
    output logic [WORD_LEN-1:0]    result
);

    // state  | meaning
    // IDLE   | waiting for a muldiv command in ID/EX
    // BUSY   | one shift-add / restoring-divide iteration per cycle
    // DONE   | result valid for one cycle, ID/EX released
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam int CNT_W = $clog2(WORD_LEN + 1);

    state_t state, state_nxt;

    logic [EXE_CMD_LEN-1:0] cmd_q;
    logic [CNT_W-1:0]       counter;
    logic [WORD_LEN-1:0]    acc, mcand, mplier;
    logic [WORD_LEN-1:0]    rem, dvd, divisor;

    logic                   start, is_divrem, div_zero, last_iter;
    logic [WORD_LEN-1:0]    acc_nxt, mcand_nxt, mplier_nxt;
    logic [WORD_LEN:0]      trial;
    logic                   trial_ge;
    logic [WORD_LEN-1:0]    rem_nxt, dvd_nxt, res_fin;

    assign is_divrem = (EXE_CMD == CMD_DIV) || (EXE_CMD == CMD_REM);
    assign start     = ((EXE_CMD == CMD_MUL) || is_divrem) && !flush;
    assign div_zero  = is_divrem && (val2 == '0);
    assign last_iter = (counter == CNT_W'(1));

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    stall     = 1'b1;
                    state_nxt = div_zero ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (flush)
                    state_nxt = S_IDLE;
                else if (last_iter)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Trial remainder is one bit wider so a large divisor never overflows the compare.
    always_comb begin
        acc_nxt    = mplier[0] ? acc + mcand : acc;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        trial      = {rem, dvd[WORD_LEN-1]};
        trial_ge   = trial >= {1'b0, divisor};
        rem_nxt    = trial_ge ? (trial[WORD_LEN-1:0] - divisor) : trial[WORD_LEN-1:0];
        dvd_nxt    = {dvd[WORD_LEN-2:0], trial_ge};
        if (cmd_q == CMD_MUL)
            res_fin = acc_nxt;
        else if (cmd_q == CMD_DIV)
            res_fin = dvd_nxt;
        else
            res_fin = rem_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cmd_q   <= '0;
            counter <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            dvd     <= '0;
            divisor <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_BUSY);
            done  <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cmd_q   <= EXE_CMD;
                        counter <= CNT_W'(WORD_LEN);
                        acc     <= '0;
                        mcand   <= val1;
                        mplier  <= val2;
                        rem     <= '0;
                        dvd     <= val1;
                        divisor <= val2;
                        if (div_zero)
                            result <= (EXE_CMD == CMD_DIV) ? '1 : val1;
                    end
                end
                S_BUSY: begin
                    if (!flush) begin
                        counter <= counter - CNT_W'(1);
                        acc     <= acc_nxt;
                        mcand   <= mcand_nxt;
                        mplier  <= mplier_nxt;
                        rem     <= rem_nxt;
                        dvd     <= dvd_nxt;
                        if (last_iter)
                            result <= res_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Randomised self-checking bench for exe_muldiv_unit against an arithmetic model.
module tb_exe_muldiv_unit;

    localparam logic [3:0] CMD_MUL = 4'hA;
    localparam logic [3:0] CMD_DIV = 4'hB;
    localparam logic [3:0] CMD_REM = 4'hC;
    localparam logic [3:0] CMD_ADD = 4'h1;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  EXE_CMD;
    logic [31:0] val1, val2;
    logic        stall, busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    exe_muldiv_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .EXE_CMD(EXE_CMD),
        .val1(val1), .val2(val2), .stall(stall), .busy(busy),
        .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        if (c == CMD_MUL) return p[31:0];
        if (b == 0)       return (c == CMD_DIV) ? 32'hFFFF_FFFF : a;
        if (c == CMD_DIV) return a / b;
        return a % b;
    endfunction

    // Issue one command and follow it to its done pulse.
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res;
        int          exp_lat, lat, bad;
        bit          got;
        exp_res = ref_result(c, a, b);
        exp_lat = (c != CMD_MUL && b == 0) ? 1 : 33;
        @(posedge clk); #1;
        EXE_CMD = c; val1 = a; val2 = b;
        @(negedge clk);
        chk("stall_at_start", stall, 1);
        @(posedge clk); #1;
        val1 = $urandom; val2 = $urandom;
        got = 0; lat = 0; bad = 0;
        for (int n = 1; n <= 100 && !got; n++) begin
            @(negedge clk);
            if (done) begin
                got = 1; lat = n;
                EXE_CMD = CMD_ADD;
            end else if (!stall || !busy) begin
                bad++;
            end
        end
        EXE_CMD = CMD_ADD;
        chk("done_seen", 32'(got), 1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("result", result, exp_res);
        chk("stall_in_done", 32'(stall), 0);
        chk("stall_busy_while_running", 32'(bad), 0);
        @(negedge clk);
        chk("done_one_pulse", 32'(done), 0);
    endtask

    initial begin
        logic [3:0]  c;
        logic [31:0] a, b, held;
        int          seen;
        rst = 1'b1; flush = 1'b0; EXE_CMD = CMD_ADD; val1 = '0; val2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_result", result, 0);
        chk("reset_stall_add", 32'(stall), 0);

        run_op(CMD_MUL, 32'd7, 32'd6);
        run_op(CMD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(CMD_DIV, 32'd100, 32'd7);
        run_op(CMD_REM, 32'd100, 32'd7);
        run_op(CMD_DIV, 32'd5, 32'd0);
        run_op(CMD_REM, 32'd5, 32'd0);
        run_op(CMD_DIV, 32'd3, 32'hFFFF_FFFF);

        // flush in the 10th BUSY cycle
        held = result;
        @(posedge clk); #1;
        EXE_CMD = CMD_MUL; val1 = 32'd12345; val2 = 32'd678;
        @(posedge clk);
        repeat (10) @(negedge clk);
        flush = 1'b1; EXE_CMD = CMD_ADD;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(busy), 0);
        chk("flush_stall", 32'(stall), 0);
        chk("flush_result_kept", result, held);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("flush_no_done", 32'(seen), 0);
        run_op(CMD_MUL, 32'd3, 32'd3);

        // reset in the middle of a divide
        @(posedge clk); #1;
        EXE_CMD = CMD_DIV; val1 = 32'd1000; val2 = 32'd3;
        @(posedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b1; EXE_CMD = CMD_ADD;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_done", 32'(done), 0);
        chk("rst_mid_result", result, 0);
        chk("rst_mid_stall", 32'(stall), 0);
        rst = 1'b0;

        // reset and flush together while running
        run_op(CMD_REM, 32'd77, 32'd10);
        @(posedge clk); #1;
        EXE_CMD = CMD_MUL; val1 = 32'd9; val2 = 32'd9;
        @(posedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1; flush = 1'b1; EXE_CMD = CMD_ADD;
        @(negedge clk);
        chk("rst_flush_busy", 32'(busy), 0);
        chk("rst_flush_done", 32'(done), 0);
        chk("rst_flush_result", result, 0);
        chk("rst_flush_stall", 32'(stall), 0);
        rst = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_add_stall", 32'(stall), 0);
        chk("idle_add_busy", 32'(busy), 0);

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 2))
                0:       c = CMD_MUL;
                1:       c = CMD_DIV;
                default: c = CMD_REM;
            endcase
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            run_op(c, a, b);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
